// File: rtl/axi_pkg.sv
// Shared AXI encodings, burst descriptor and FSM state types for the slave memory.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_desc_t;

  typedef enum logic [1:0] {WI, WD, WB} wr_state_e;
  typedef enum logic {RI, RD} rd_state_e;

  // Whole-burst legality except WRAP length: the lowest and highest beat
  // addresses are derived up front so the outcome is known before beat 0.
  function automatic logic desc_err(axi_desc_t d, logic [31:0] base, logic [33:0] lim);
    logic [33:0] sz, span, a, lo, hi;
    sz   = 34'd1 << d.size;
    span = sz * ({26'd0, d.len} + 34'd1);
    a    = {2'b00, d.addr};
    case (d.burst)
      BURST_FIXED: begin lo = a; hi = a; end
      BURST_INCR:  begin lo = a; hi = a + span - sz; end
      default:     begin lo = a & ~(span - 34'd1); hi = lo + span - sz; end
    endcase
    return (d.size > 3'd2) || (d.burst == 2'b11) ||
           (a < {2'b00, base}) || (a >= lim) ||
           (lo < {2'b00, base}) || (hi >= lim);
  endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address generator and WRAP length legality check.
module axi_burst_addr
  import axi_pkg::*;
(
  input  logic [31:0] addr_i,
  input  logic [7:0]  len_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  burst_i,
  output logic [31:0] next_addr_o,
  output logic        wrap_ok_o
);

  logic [31:0] sz;
  logic [31:0] mask;

  always_comb begin
    sz        = 32'd1 << size_i;
    mask      = (sz * ({24'd0, len_i} + 32'd1)) - 32'd1;
    wrap_ok_o = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (addr_i & ~mask) | ((addr_i + sz) & mask);
      default:     next_addr_o = addr_i + sz;
    endcase
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory-backed slave: DEPTH x 32-bit RAM behind independent write and read burst engines.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [1:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int unsigned IW    = $clog2(DEPTH);
  localparam logic [33:0] LIMIT = {2'b00, BASE_ADDR} + 34'(4 * DEPTH);

  logic [31:0] mem [DEPTH];

  function automatic logic [IW-1:0] widx(logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  // ---------------- write path ----------------
  wr_state_e   wst_q, wst_d;
  axi_desc_t   aw_q, aw_d, wa_in;
  logic [7:0]  wbeat_q, wbeat_d;
  logic        werr_q, werr_d, wlerr_q, wlerr_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] w_next;
  logic        w_wrap_ok, w_acc_err, w_hs, w_last_beat;

  // The address unit sees the incoming descriptor while idle so beat-0 legality is known at accept.
  always_comb begin
    wa_in = aw_q;
    if (wst_q == WI) begin
      wa_in.addr  = AWADDR;
      wa_in.len   = AWLEN;
      wa_in.size  = AWSIZE;
      wa_in.burst = AWBURST;
    end
  end

  axi_burst_addr u_waddr (
    .addr_i      (wa_in.addr),
    .len_i       (wa_in.len),
    .size_i      (wa_in.size),
    .burst_i     (wa_in.burst),
    .next_addr_o (w_next),
    .wrap_ok_o   (w_wrap_ok)
  );

  assign w_acc_err   = desc_err(wa_in, BASE_ADDR, LIMIT) || ((wa_in.burst == BURST_WRAP) && !w_wrap_ok);
  assign w_hs        = (wst_q == WD) && WVALID && wready_q;
  assign w_last_beat = (wbeat_q == aw_q.len);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst_q     <= WI;
      aw_q      <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      wlerr_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      wst_q     <= wst_d;
      aw_q      <= aw_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      wlerr_q   <= wlerr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      WI:      if (AWVALID && awready_q) wst_d = WD;
      WD:      if (w_hs && w_last_beat) wst_d = WB;
      WB:      if (BREADY) wst_d = WI;
      default: wst_d = WI;
    endcase
  end

  always_comb begin
    aw_d      = aw_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    wlerr_d   = wlerr_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    case (wst_q)
      WI: if (AWVALID && awready_q) begin
        aw_d      = wa_in;
        werr_d    = w_acc_err;
        wlerr_d   = 1'b0;
        wbeat_d   = '0;
        awready_d = 1'b0;
        wready_d  = 1'b1;
      end
      WD: if (w_hs) begin
        aw_d.addr = w_next;
        wbeat_d   = wbeat_q + 8'd1;
        if (WLAST != w_last_beat) wlerr_d = 1'b1;
        if (w_last_beat) begin
          wready_d = 1'b0;
          bvalid_d = 1'b1;
          bresp_d  = (werr_q || wlerr_q || (WLAST != w_last_beat)) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      WB: if (BREADY) begin
        bvalid_d  = 1'b0;
        awready_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_hs && !werr_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem[widx(aw_q.addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e   rdst_q, rdst_d;
  axi_desc_t   ar_q, ar_d, ra_in;
  logic [7:0]  rbeat_q, rbeat_d;
  logic        rerr_q, rerr_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d, r_next, rd_word;
  logic [1:0]  rresp_q, rresp_d;
  logic        r_wrap_ok, r_acc_err;

  // ar_q.addr always holds the address of the next beat still to be fetched.
  always_comb begin
    ra_in = ar_q;
    if (rdst_q == RI) begin
      ra_in.addr  = ARADDR;
      ra_in.len   = ARLEN;
      ra_in.size  = ARSIZE;
      ra_in.burst = ARBURST;
    end
  end

  axi_burst_addr u_raddr (
    .addr_i      (ra_in.addr),
    .len_i       (ra_in.len),
    .size_i      (ra_in.size),
    .burst_i     (ra_in.burst),
    .next_addr_o (r_next),
    .wrap_ok_o   (r_wrap_ok)
  );

  assign r_acc_err = desc_err(ra_in, BASE_ADDR, LIMIT) || ((ra_in.burst == BURST_WRAP) && !r_wrap_ok);
  assign rd_word   = mem[widx(ra_in.addr)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdst_q    <= RI;
      ar_q      <= '0;
      rbeat_q   <= '0;
      rerr_q    <= 1'b0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      rdst_q    <= rdst_d;
      ar_q      <= ar_d;
      rbeat_q   <= rbeat_d;
      rerr_q    <= rerr_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  always_comb begin
    rdst_d = rdst_q;
    case (rdst_q)
      RI:      if (ARVALID && arready_q) rdst_d = RD;
      RD:      if (RREADY && rlast_q) rdst_d = RI;
      default: rdst_d = RI;
    endcase
  end

  always_comb begin
    ar_d      = ar_q;
    rbeat_d   = rbeat_q;
    rerr_d    = rerr_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (rdst_q)
      RI: if (ARVALID && arready_q) begin
        ar_d      = ra_in;
        ar_d.addr = r_next;
        rbeat_d   = '0;
        rerr_d    = r_acc_err;
        arready_d = 1'b0;
        rvalid_d  = 1'b1;
        rlast_d   = (ARLEN == 8'd0);
        rdata_d   = r_acc_err ? '0 : rd_word;
        rresp_d   = r_acc_err ? RESP_SLVERR : RESP_OKAY;
      end
      RD: if (RREADY) begin
        if (rlast_q) begin
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          arready_d = 1'b1;
        end else begin
          ar_d.addr = r_next;
          rbeat_d   = rbeat_q + 8'd1;
          rlast_d   = ((rbeat_q + 8'd1) == ar_q.len);
          rdata_d   = rerr_q ? '0 : rd_word;
        end
      end
      default: ;
    endcase
  end

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RDATA   = rdata_q;
  assign RRESP   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem with a burst-level memory model and a per-cycle response checker.
module tb_axi_slave_mem;

  localparam longint TB_BASE  = 0;
  localparam int     TB_DEPTH = 256;

  logic        clk, rst;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  axi_slave_mem #(.DEPTH(TB_DEPTH), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
    logic        l;
  } rexp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mm [TB_DEPTH];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  rexp_t       exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] got_r[$];
  logic        got_l[$];
  logic [1:0]  last_b;
  rexp_t       e;
  logic [1:0]  eb;
  logic        r_hold = 1'b0;
  logic [31:0] prev_rd;
  logic [1:0]  prev_rr;
  logic        prev_rl;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic int unsigned midx(logic [31:0] a);
    return int'(((longint'(a) - TB_BASE) >> 2) % TB_DEPTH);
  endfunction

  function automatic logic [31:0] nxt(logic [31:0] a, int size, int len, int burst);
    longint sz, blk, lo;
    sz  = longint'(1) << size;
    blk = sz * (len + 1);
    case (burst)
      0: return a;
      2: begin
        lo = longint'(a) - (longint'(a) % blk);
        return 32'(lo + ((longint'(a) - lo + sz) % blk));
      end
      default: return 32'(longint'(a) + sz);
    endcase
  endfunction

  function automatic logic bad(logic [31:0] a, int len, int size, int burst);
    logic [31:0] ad;
    if (size > 2 || burst == 3) return 1'b1;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
    ad = a;
    for (int i = 0; i <= len; i++) begin
      if (longint'(ad) < TB_BASE || longint'(ad) >= TB_BASE + 4 * TB_DEPTH) return 1'b1;
      ad = nxt(ad, size, len, burst);
    end
    return 1'b0;
  endfunction

  // Per-cycle checker: every completed R/B handshake against the model, plus R hold under stall.
  always @(negedge clk) begin
    if (rst) begin
      r_hold = 1'b0;
    end else begin
      if (r_hold) begin
        chk("rdata_hold", RDATA, prev_rd);
        chk("rresp_hold", RRESP, prev_rr);
        chk("rlast_hold", RLAST, prev_rl);
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) chk("r_extra_beat", 1, 0);
        else begin
          e = exp_r.pop_front();
          chk("rdata", RDATA, e.d);
          chk("rresp", RRESP, e.r);
          chk("rlast", RLAST, e.l);
          got_r.push_back(RDATA);
          got_l.push_back(RLAST);
        end
      end
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) chk("b_extra", 1, 0);
        else begin
          eb = exp_b.pop_front();
          chk("bresp", BRESP, eb);
          last_b = BRESP;
        end
      end
      r_hold  = RVALID && !RREADY;
      prev_rd = RDATA;
      prev_rr = RRESP;
      prev_rl = RLAST;
    end
  end

  task automatic do_write(input logic [31:0] a, input int len, input int size, input int burst,
                          input int wlast_at, input bit rnd);
    logic [31:0] ad;
    logic        err;
    int          to;
    bit          done;
    err = bad(a, len, size, burst);
    ad  = a;
    for (int i = 0; i <= len; i++) begin
      if (!err)
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) mm[midx(ad)][8*b +: 8] = wbuf[i][8*b +: 8];
      ad = nxt(ad, size, len, burst);
    end
    exp_b.push_back((err || wlast_at != len) ? 2'b10 : 2'b00);
    AWADDR = a; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst); AWVALID = 1'b1;
    to = 0;
    do begin @(negedge clk); to++; end while (!AWREADY && to < 100);
    if (!AWREADY) chk("aw_timeout", 0, 1);
    @(posedge clk); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (rnd) begin
        WVALID = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      WDATA = wbuf[i]; WSTRB = sbuf[i]; WLAST = (i == wlast_at); WVALID = 1'b1;
      to = 0;
      do begin @(negedge clk); to++; end while (!WREADY && to < 100);
      if (!WREADY) chk("w_timeout", 0, 1);
      @(posedge clk); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    to = 0; done = 0;
    while (!done && to < 100) begin
      BREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (BVALID && BREADY) done = 1;
      @(posedge clk); #1;
      to++;
    end
    BREADY = 1'b0;
    if (!done) chk("b_timeout", 0, 1);
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input int size, input int burst, input bit rnd);
    logic [31:0] ad;
    logic        err;
    int          to, cnt;
    err = bad(a, len, size, burst);
    ad  = a;
    for (int i = 0; i <= len; i++) begin
      exp_r.push_back('{err ? 32'h0 : mm[midx(ad)], err ? 2'b10 : 2'b00, i == len});
      ad = nxt(ad, size, len, burst);
    end
    got_r.delete(); got_l.delete();
    ARADDR = a; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst); ARVALID = 1'b1;
    to = 0;
    do begin @(negedge clk); to++; end while (!ARREADY && to < 100);
    if (!ARREADY) chk("ar_timeout", 0, 1);
    @(posedge clk); #1;
    ARVALID = 1'b0;
    cnt = 0; to = 0;
    while (cnt <= len && to < 400) begin
      RREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (RVALID && RREADY) cnt++;
      @(posedge clk); #1;
      to++;
    end
    RREADY = 1'b0;
    if (cnt <= len) chk("r_timeout", cnt, len + 1);
  endtask

  task automatic fill(input logic [31:0] base, input int n, input logic [3:0] s);
    for (int i = 0; i < n; i++) begin
      wbuf[i] = base + 32'(i);
      sbuf[i] = s;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < TB_DEPTH; i++) mm[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", AWREADY, 1); chk("rst_arready", ARREADY, 1);
    chk("rst_wready", WREADY, 0);   chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);   chk("rst_rlast", RLAST, 0);
    chk("rst_bresp", BRESP, 0);     chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    chk("model_wrap", nxt(32'h1C, 2, 3, 2), 32'h10);
    chk("model_cross_err", 32'(bad(32'h3F8, 3, 2, 1)), 1);
    @(posedge clk); #1;

    // 1: INCR write then read back
    fill(32'hA0, 4, 4'hF);
    do_write(32'h10, 3, 2, 1, 3, 0);
    chk("t1_bresp", last_b, 2'b00);
    do_read(32'h10, 3, 2, 1, 0);
    chk("t1_r0", got_r[0], 32'hA0); chk("t1_r3", got_r[3], 32'hA3);
    chk("t1_last3", got_l[3], 1);   chk("t1_last2", got_l[2], 0);

    // 2: WRAP write landing 0x18,0x1C,0x10,0x14
    fill(32'hD0, 4, 4'hF);
    do_write(32'h18, 3, 2, 2, 3, 0);
    do_read(32'h10, 3, 2, 1, 0);
    chk("t2_r0", got_r[0], 32'hD2); chk("t2_r1", got_r[1], 32'hD3);
    chk("t2_r2", got_r[2], 32'hD0); chk("t2_r3", got_r[3], 32'hD1);

    // 3: partial strobe merge and FIXED read
    wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
    do_write(32'h20, 0, 2, 1, 0, 0);
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'b0011;
    do_write(32'h20, 0, 2, 1, 0, 0);
    do_read(32'h20, 3, 2, 0, 0);
    chk("t3_r0", got_r[0], 32'h1234FFFF); chk("t3_r3", got_r[3], 32'h1234FFFF);

    // 4: out-of-range writes leave RAM untouched; reserved burst reads SLVERR
    wbuf[0] = 32'h11111111; sbuf[0] = 4'hF;
    do_write(32'h0, 0, 2, 1, 0, 0);
    wbuf[0] = 32'h22222222;
    do_write(32'h3F8, 0, 2, 1, 0, 0);
    fill(32'hDEAD0000, 4, 4'hF);
    do_write(32'h400, 0, 2, 1, 0, 0);
    chk("t4_bresp_oor", last_b, 2'b10);
    do_write(32'h3F8, 3, 2, 1, 3, 0);
    chk("t4_bresp_cross", last_b, 2'b10);
    do_read(32'h0, 0, 2, 1, 0);
    chk("t4_word0", got_r[0], 32'h11111111);
    do_read(32'h3F8, 0, 2, 1, 0);
    chk("t4_word3f8", got_r[0], 32'h22222222);
    do_read(32'h10, 1, 2, 3, 0);
    chk("t4_rsv_beats", got_r.size(), 2); chk("t4_rsv_data", got_r[1], 0);
    do_read(32'h10, 2, 2, 2, 0);
    do_read(32'h0, 0, 3, 1, 0);

    // 5: concurrent AW+AR with random stalls on every handshake
    fill(32'h5500, 8, 4'hF);
    fork
      do_write(32'h80, 7, 2, 1, 7, 1);
      do_read(32'h10, 3, 2, 1, 1);
    join
    do_read(32'h80, 7, 2, 1, 1);
    chk("t5_r7", got_r[7], 32'h5507);
    fill(32'h6600, 8, 4'hF);
    fork
      do_write(32'hC0, 7, 2, 2, 7, 1);
      do_read(32'h80, 7, 2, 2, 1);
    join
    do_read(32'hC0, 7, 2, 1, 1);

    // 6: early WLAST still writes; reset during a read burst
    fill(32'h7700, 4, 4'hF);
    do_write(32'h40, 3, 2, 1, 1, 0);
    chk("t6_bresp_wlast", last_b, 2'b10);
    do_read(32'h40, 3, 2, 1, 0);
    chk("t6_r3", got_r[3], 32'h7703);
    ARADDR = 32'h40; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 1'b1; RREADY = 1'b0;
    @(posedge clk); #1;
    ARVALID = 1'b0;
    @(negedge clk);
    chk("t6_rvalid_pre", RVALID, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_rst_rvalid", RVALID, 0);
    chk("t6_rst_arready", ARREADY, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    do_read(32'h44, 0, 2, 1, 0);
    chk("t6_retained", got_r[0], 32'h7701);
    chk("q_r_empty", exp_r.size(), 0);
    chk("q_b_empty", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
